pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 64'h0000_0000_0000_0000, meaning the first PC fetched after reset.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, meaning the width of the accepted-fetch counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1, pipeline back-pressure; when high, no sequential advance and fetchValid is low.
REQ-006 SHALL have port redirectValid, input, 1, branch/jump redirect request.
REQ-007 SHALL have port redirectTarget, input, 64, redirect destination.
REQ-008 SHALL have port trapValid, input, 1, trap request; has priority over redirect.
REQ-009 SHALL have port trapVector, input, 64, trap destination.
REQ-010 SHALL have port fetchReady, input, 1, instruction memory accepts the request this cycle.
REQ-011 SHALL have port fetchValid, output, 1, fetch request valid for the current pc.
REQ-012 SHALL have port pc, output, 64, current fetch address, registered.
REQ-013 SHALL have port nextPc, output, 64, combinational value pc takes at the next edge.
REQ-014 SHALL have port fetchCount, output, COUNT_WIDTH, number of accepted fetches, modulo 2^COUNT_WIDTH.
REQ-015 SHALL have port misalignedErr, output, 1, sticky misaligned-redirect flag (see Configuration).

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH and FLUSH.
REQ-017 IDLE SHALL go to FETCH unconditionally on the first edge after reset deasserts, with fetchValid=0 while in IDLE.
REQ-018 fetchValid SHALL equal (state==FETCH) && !stall, so it is 0 in IDLE and FLUSH.
REQ-019 A handshake SHALL occur when fetchValid && fetchReady; on a handshake only, fetchCount increments by 1, wrapping to 0.
REQ-020 Next-PC priority SHALL be: trapValid (trapVector), then redirectValid (redirectTarget), then handshake (pc+4), else hold pc.
REQ-021 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC to 0), with no flag raised.
REQ-022 trapValid and redirectValid SHALL be honoured in any state other than IDLE, including while stall is high, and SHALL move the FSM to FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle (a bubble) and then go to FETCH; a new trap/redirect during FLUSH SHALL update pc and re-enter FLUSH.
REQ-024 If trapValid and redirectValid are asserted together, the redirect SHALL be dropped.
REQ-025 A redirect or trap coinciding with a handshake SHALL count the handshake, but pc SHALL take the redirect/trap target rather than pc+4.
REQ-026 Latency SHALL be: a redirect/trap asserted in cycle N gives pc=target in N+1 with fetchValid=0, then fetchValid=1 in N+2 if stall is low.

Reset
REQ-027 While reset is high, the block SHALL hold pc=RESET_VECTOR, state=IDLE, fetchValid=0, fetchCount=0 and misalignedErr=0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL abandon any pending redirect/trap and SHALL restart at IDLE.
REQ-029 nextPc SHALL equal RESET_VECTOR while reset is high.

Configuration
REQ-030 Macro PC_MISALIGN_CHECK_EN SHALL control misaligned-redirect checking.
REQ-031 With PC_MISALIGN_CHECK_EN defined, a redirect with redirectTarget[1:0]!=0 SHALL set misalignedErr (sticky until reset) and SHALL load trapVector instead of the target.
REQ-032 Without PC_MISALIGN_CHECK_EN, redirectTarget[1:0] SHALL be forced to 2'b00, misalignedErr SHALL be tied 0, and no check logic SHALL be present.
REQ-033 Trap vectors SHALL never be checked or modified in either configuration.

Structure
REQ-034 Package pc_seq_pkg SHALL hold the FSM state typedef, INSTR_BYTES=4 and ALIGN_MASK=64'hFFFF_FFFF_FFFF_FFFC.
REQ-035 Sub-module pc_reg SHALL be a 64-bit register with asynchronous reset to RESET_VECTOR that loads nextPc every cycle.
REQ-036 The FSM, priority mux, counter and check logic SHALL reside in pc_sequencer.

Verification
REQ-037 Reset sequence: release reset with fetchReady=1 and stall=0 -> cycle 0 IDLE with fetchValid=0, then pc=0, 4, 8 on successive cycles and fetchCount=3 after three handshakes.
REQ-038 Stall: assert stall for 3 cycles at pc=0x100 -> pc holds 0x100, fetchValid=0, fetchCount unchanged, then resumes at 0x104.
REQ-039 Simultaneous trap and redirect (target 0x2000, trapVector 0x8000) -> pc=0x8000 next cycle, one FLUSH bubble, then fetch at 0x8000.
REQ-040 Wrap: RESET_VECTOR=64'hFFFF_FFFF_FFFF_FFFC with one handshake -> pc=0.
REQ-041 Misalign: redirect to 0x1002 -> with PC_MISALIGN_CHECK_EN, pc=trapVector and misalignedErr=1 (still 1 after further fetches); without it, pc=0x1000 and misalignedErr=0.
REQ-042 Reset asserted during FLUSH -> outputs go to reset values immediately without waiting for a clock edge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: the FSM state encoding,
// the instruction size and the word-alignment mask.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } pc_state_e;

  localparam logic [63:0] INSTR_BYTES = 64'd4;
  localparam logic [63:0] ALIGN_MASK  = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage

// File: rtl/pc_reg.sv
// 64-bit program-counter register. Asynchronously resets to RESET_VECTOR and
// otherwise loads the next-PC value on every rising edge.
module pc_reg
  import pc_seq_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_d,
  output logic [63:0] pc_q
);

  // PC storage: unconditional load, hold behaviour is decided upstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: IDLE/FETCH/FLUSH FSM, next-PC priority mux
// (trap > redirect > sequential > hold), accepted-fetch counter.
// Optional build macro PC_MISALIGN_CHECK_EN: a redirect to a non-word-aligned
// target raises a sticky misalignedErr and vectors to trapVector instead;
// without it the low two target bits are simply cleared.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
  parameter int          COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirectValid,
  input  logic [63:0]            redirectTarget,
  input  logic                   trapValid,
  input  logic [63:0]            trapVector,
  input  logic                   fetchReady,
  output logic                   fetchValid,
  output logic [63:0]            pc,
  output logic [63:0]            nextPc,
  output logic [COUNT_WIDTH-1:0] fetchCount,
  output logic                   misalignedErr
);

  pc_state_e              state_q, state_d;
  logic [COUNT_WIDTH-1:0] fetch_count_q, fetch_count_d;
  logic [63:0]            pc_q, pc_d;
  logic [63:0]            redirect_pc;
  logic                   handshake;

  assign fetchValid = (state_q == FETCH) && !stall;
  assign handshake  = fetchValid && fetchReady;

`ifdef PC_MISALIGN_CHECK_EN
  logic misaligned_err_q, misaligned_err_d;
  logic redirect_bad;

  // A misaligned redirect is converted into a trap-vector fetch
  always_comb begin
    redirect_bad = |redirectTarget[1:0];
    redirect_pc  = redirect_bad ? trapVector : redirectTarget;
  end

  assign misalignedErr = misaligned_err_q;
`else
  // Without checking, the target is silently forced onto a word boundary
  always_comb begin
    redirect_pc = redirectTarget & ALIGN_MASK;
  end

  assign misalignedErr = 1'b0;
`endif

  // Next-state, next-PC and counter logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
`ifdef PC_MISALIGN_CHECK_EN
    misaligned_err_d = misaligned_err_q;
`endif
    // A handshake is counted even when a redirect/trap overrides the PC
    if (handshake) fetch_count_d = fetch_count_q + COUNT_WIDTH'(1);
    case (state_q)
      IDLE: state_d = FETCH;
      default: begin
        if (trapValid) begin
          pc_d    = trapVector;
          state_d = FLUSH;
        end else if (redirectValid) begin
          pc_d    = redirect_pc;
          state_d = FLUSH;
`ifdef PC_MISALIGN_CHECK_EN
          if (redirect_bad) misaligned_err_d = 1'b1;
`endif
        end else begin
          state_d = FETCH;
          if (handshake) pc_d = pc_q + INSTR_BYTES;
        end
      end
    endcase
  end

  // Reset forces the externally visible next PC to the reset vector too
  assign nextPc     = reset ? RESET_VECTOR : pc_d;
  assign pc         = pc_q;
  assign fetchCount = fetch_count_q;

  // FSM state and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_count_q <= '0;
`ifdef PC_MISALIGN_CHECK_EN
      misaligned_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_count_q <= fetch_count_d;
`ifdef PC_MISALIGN_CHECK_EN
      misaligned_err_q <= misaligned_err_d;
`endif
    end
  end

  pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .pc_d  (nextPc),
    .pc_q  (pc_q)
  );

endmodule
